// File: rtl/stream_capture_module.sv
// Captures a frame of N_WORDS stream words into a host-readable memory; optional checksum under CAPTURE_CHECKSUM_EN.
// Latency: a word is stored on its transfer cycle; rd_data is registered one cycle after rd_addr.
// Backpressure: x_tready is high only in CAPTURE and comes straight from state, never from x_tvalid.
module stream_capture_module #(
    parameter int N_WORDS      = 784,
    parameter int n_bits       = 32,
    parameter int addressWidth = 32
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic                    start,
    input  logic [n_bits-1:0]       x_tdata,
    input  logic                    x_tvalid,
    output logic                    x_tready,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             word_count,
    input  logic [addressWidth-1:0] rd_addr,
    output logic [n_bits-1:0]       rd_data,
    output logic [31:0]             checksum
);

    localparam int MEM_AW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                start_q, start_d;
    logic                start_rst_q, start_rst_d;
    logic [15:0]         word_count_q, word_count_d;
    logic [n_bits-1:0]   rd_data_q, rd_data_d;
    logic [n_bits-1:0]   mem_q [N_WORDS];

    logic                start_edge;
    logic                xfer;
    logic                wr_en;
    logic [MEM_AW-1:0]   wr_idx;
    logic [MEM_AW-1:0]   rd_idx;
    logic                rd_in_range;

    // start_rst_q remembers a start level seen during reset so it is not taken as an edge on release.
    always_comb begin
        start_d     = start;
        start_rst_d = start & s_axi_areset;
        start_edge  = start & ~start_q & ~start_rst_q;
        xfer        = (state_q == CAPTURE) & x_tvalid & ~start_edge
                      & (word_count_q < 16'(N_WORDS));
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            word_count_q <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            word_count_q <= word_count_d;
            rd_data_q    <= rd_data_d;
        end
        start_rst_q <= start_rst_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_edge) begin
            state_d = CAPTURE;
        end else begin
            case (state_q)
                CAPTURE: if (xfer && word_count_q == 16'(N_WORDS - 1)) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        x_tready   = (state_q == CAPTURE);
        busy       = (state_q == CAPTURE);
        done       = (state_q == DONE);
        word_count = word_count_q;
        rd_data    = rd_data_q;
    end

    always_comb begin
        word_count_d = word_count_q;
        if (start_edge) begin
            word_count_d = '0;
        end else if (xfer) begin
            word_count_d = word_count_q + 16'd1;
        end
    end

    // Range check on the full byte address so the upper index bits are honoured.
    always_comb begin
        wr_en       = xfer & ~s_axi_areset;
        wr_idx      = word_count_q[MEM_AW-1:0];
        rd_idx      = rd_addr[MEM_AW+1:2];
        rd_in_range = (rd_addr < addressWidth'(4 * N_WORDS));
        rd_data_d   = rd_in_range ? mem_q[rd_idx] : '0;
    end

    // Memory is deliberately left out of reset so a frame survives an abandoned capture.
    always_ff @(posedge s_axi_aclk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= x_tdata;
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_edge) begin
            checksum_d = '0;
        end else if (xfer) begin
            checksum_d = checksum_q + 32'(x_tdata);
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_stream_capture_module.sv
// Directed bench for stream_capture_module: vector table for start/transfer interplay plus frame-level sequences.
module tb_stream_capture_module;

    localparam int NW = 784;

`ifdef CAPTURE_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        s_axi_areset;
    logic        start;
    logic [31:0] x_tdata;
    logic        x_tvalid;
    logic        x_tready;
    logic        busy;
    logic        done;
    logic [15:0] word_count;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [31:0] checksum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_capture_module #(
        .N_WORDS     (NW),
        .n_bits      (32),
        .addressWidth(32)
    ) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(s_axi_areset),
        .start       (start),
        .x_tdata     (x_tdata),
        .x_tvalid    (x_tvalid),
        .x_tready    (x_tready),
        .busy        (busy),
        .done        (done),
        .word_count  (word_count),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .checksum    (checksum)
    );

    typedef struct {
        logic        start;
        logic        tvalid;
        logic [31:0] tdata;
        logic        exp_rdy;
        logic        exp_done;
        logic [15:0] exp_wc;
        logic [31:0] exp_ck;
    } vec_t;

    vec_t vt[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ck(input logic [31:0] v);
        return CK_EN ? v : 32'd0;
    endfunction

    task automatic start_frame(input string tag);
        start    = 1'b1;
        x_tvalid = 1'b0;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_wc0"}, 32'(word_count), 32'd0);
        chk({tag, "_done0"}, 32'(done), 32'd0);
    endtask

    initial begin
        int          n;
        logic [31:0] sum;
        logic        acc;

        vt[0] = '{1'b1, 1'b1, 32'h0000_00AA, 1'b0, 1'b0, 16'd0, 32'h00};
        vt[1] = '{1'b0, 1'b1, 32'h0000_00BB, 1'b0, 1'b0, 16'd0, 32'h00};
        vt[2] = '{1'b1, 1'b1, 32'h0000_00CC, 1'b1, 1'b0, 16'd0, 32'h00};
        vt[3] = '{1'b1, 1'b1, 32'h0000_0011, 1'b1, 1'b0, 16'd1, 32'h11};
        vt[4] = '{1'b0, 1'b0, 32'h0000_00DD, 1'b1, 1'b0, 16'd1, 32'h11};
        vt[5] = '{1'b0, 1'b1, 32'h0000_0022, 1'b1, 1'b0, 16'd2, 32'h33};
        vt[6] = '{1'b1, 1'b1, 32'h0000_0033, 1'b1, 1'b0, 16'd0, 32'h00};
        vt[7] = '{1'b1, 1'b1, 32'h0000_0044, 1'b1, 1'b0, 16'd1, 32'h44};
        vt[8] = '{1'b0, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 16'd2, 32'h99};

        // Reset with start held high: must not be seen as an edge afterwards.
        s_axi_areset = 1'b1;
        start        = 1'b1;
        x_tvalid     = 1'b1;
        x_tdata      = 32'hDEAD_BEEF;
        rd_addr      = 32'd0;
        tick();
        tick();
        chk("rst_tready", 32'(x_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_ck", checksum, 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        s_axi_areset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start    = vt[i].start;
            x_tvalid = vt[i].tvalid;
            x_tdata  = vt[i].tdata;
            tick();
            chk($sformatf("vec%0d_rdy", i), 32'(x_tready), 32'(vt[i].exp_rdy));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_rdy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].exp_done));
            chk($sformatf("vec%0d_wc", i), 32'(word_count), 32'(vt[i].exp_wc));
            chk($sformatf("vec%0d_ck", i), checksum, ck(vt[i].exp_ck));
        end
        start    = 1'b0;
        x_tvalid = 1'b0;
        rd_addr  = 32'd0;
        tick();
        chk("vec_rd0", rd_data, 32'h44);
        rd_addr = 32'd4;
        tick();
        chk("vec_rd1", rd_data, 32'h55);

        // Full frame, back-to-back transfers.
        start_frame("full");
        sum = 32'd0;
        for (int i = 0; i < NW; i++) begin
            x_tvalid = 1'b1;
            x_tdata  = 32'(i);
            sum      = sum + 32'(i);
            tick();
            chk($sformatf("full_wc%0d", i), 32'(word_count), 32'(i + 1));
            chk($sformatf("full_done%0d", i), 32'(done), 32'(i == NW - 1));
        end
        chk("full_tready", 32'(x_tready), 32'd0);
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_ck", checksum, ck(32'd306936));
        chk("full_ck_model", checksum, ck(sum));
        x_tdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) tick();
        chk("full_post_wc", 32'(word_count), 32'd784);
        chk("full_post_done", 32'(done), 32'd1);
        chk("full_post_ck", checksum, ck(32'd306936));
        x_tvalid = 1'b0;
        for (int a = 0; a < NW; a++) begin
            rd_addr = 32'(a * 4);
            tick();
            chk($sformatf("sweep_rd%0d", a), rd_data, 32'(a));
        end
        rd_addr = 32'd3136;
        tick();
        chk("sweep_oob", rd_data, 32'd0);
        rd_addr = 32'hFFFF_FFFC;
        tick();
        chk("sweep_oob_max", rd_data, 32'd0);

        // Random valid gaps.
        start_frame("rand");
        n   = 0;
        sum = 32'd0;
        for (int c = 0; c < 6000 && n < NW; c++) begin
            x_tvalid = 1'($urandom_range(0, 1));
            x_tdata  = 32'hA5A5_0000 + 32'(n);
            acc      = x_tvalid & x_tready;
            tick();
            if (acc) begin
                sum = sum + x_tdata;
                n++;
            end
            chk($sformatf("rand_wc_c%0d", c), 32'(word_count), 32'(n));
            chk($sformatf("rand_done_c%0d", c), 32'(done), 32'(n == NW));
        end
        chk("rand_all_accepted", 32'(n), 32'(NW));
        chk("rand_ck", checksum, ck(sum));
        x_tvalid = 1'b1;
        x_tdata  = 32'h1234_5678;
        for (int i = 0; i < 4; i++) tick();
        chk("rand_post_wc", 32'(word_count), 32'd784);
        chk("rand_post_ck", checksum, ck(sum));
        x_tvalid = 1'b0;
        for (int a = 0; a < NW; a++) begin
            rd_addr = 32'(a * 4);
            tick();
            chk($sformatf("rand_rd%0d", a), rd_data, 32'hA5A5_0000 + 32'(a));
        end

        // Reset mid-capture abandons the frame but keeps memory.
        start_frame("rstmid");
        for (int i = 0; i < 100; i++) begin
            x_tvalid = 1'b1;
            x_tdata  = 32'h0000_B000 + 32'(i);
            tick();
        end
        chk("rstmid_wc100", 32'(word_count), 32'd100);
        s_axi_areset = 1'b1;
        x_tdata      = 32'h0000_0BAD;
        tick();
        s_axi_areset = 1'b0;
        x_tvalid     = 1'b0;
        chk("rstmid_wc", 32'(word_count), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_tready", 32'(x_tready), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_ck", checksum, 32'd0);
        rd_addr = 32'd200;
        tick();
        chk("rstmid_rd50", rd_data, 32'h0000_B032);
        rd_addr = 32'd400;
        tick();
        chk("rstmid_rd100", rd_data, 32'hA5A5_0064);
        chk("rstmid_idle", 32'(busy), 32'd0);

        // Restart after 200 words, read-during-write, start coincident with a transfer.
        start_frame("rs");
        for (int i = 0; i < 200; i++) begin
            x_tvalid = 1'b1;
            x_tdata  = 32'h0000_C000 + 32'(i);
            tick();
        end
        chk("rs_wc200", 32'(word_count), 32'd200);
        start    = 1'b1;
        x_tvalid = 1'b0;
        tick();
        start = 1'b0;
        chk("rs_restart_wc", 32'(word_count), 32'd0);
        chk("rs_restart_busy", 32'(busy), 32'd1);
        x_tvalid = 1'b1;
        x_tdata  = 32'h0000_D000;
        tick();
        chk("rs_wc1", 32'(word_count), 32'd1);
        x_tdata = 32'h0000_D001;
        rd_addr = 32'd4;
        tick();
        chk("rs_wc2", 32'(word_count), 32'd2);
        chk("rs_rdw_old", rd_data, 32'h0000_C001);
        x_tdata = 32'h0000_D002;
        rd_addr = 32'd0;
        tick();
        chk("rs_wc3", 32'(word_count), 32'd3);
        chk("rs_rd0_new", rd_data, 32'h0000_D000);
        start   = 1'b1;
        x_tdata = 32'h0000_EEEE;
        rd_addr = 32'd12;
        tick();
        start    = 1'b0;
        x_tvalid = 1'b0;
        chk("rs_coinc_wc", 32'(word_count), 32'd0);
        chk("rs_coinc_ck", checksum, 32'd0);
        chk("rs_coinc_rd3_old", rd_data, 32'h0000_C003);
        tick();
        chk("rs_discard_rd3", rd_data, 32'h0000_C003);
        rd_addr = 32'd8;
        tick();
        chk("rs_rd2", rd_data, 32'h0000_D002);
        rd_addr = 32'd796;
        tick();
        chk("rs_rd199", rd_data, 32'h0000_C0C7);
        rd_addr = 32'd800;
        tick();
        chk("rs_rd200", rd_data, 32'hA5A5_00C8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
